// File: rtl/intr_collector.sv
// intr_collector: gathers one-shot interrupt requests from N_ENG engines into
// per-channel pending slots and issues them one at a time to a single host
// interrupt port. Channels are picked round-robin. An issue that the host
// never acknowledges is abandoned after TIMEOUT cycles and retried later.
module intr_collector #(
    parameter int N_ENG   = 4,
    parameter int CTXW    = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_ENG-1:0]        eng_req,
    input  logic [64*N_ENG-1:0]     eng_src,
    input  logic [CTXW*N_ENG-1:0]   eng_ctx,
    output logic [N_ENG-1:0]        eng_ack,
    output logic                    host_req,
    output logic [63:0]             host_src,
    output logic [CTXW-1:0]         host_ctx,
    input  logic                    host_ack,
    output logic [N_ENG-1:0]        ovf_sticky,
    output logic [N_ENG-1:0]        tmo_sticky,
    input  logic                    sticky_clr
);

    localparam int GW = $clog2(N_ENG);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_ENG-1:0]  pending_q, pending_d;
    logic [63:0]       ch_src_q [N_ENG];
    logic [63:0]       ch_src_d [N_ENG];
    logic [CTXW-1:0]   ch_ctx_q [N_ENG];
    logic [CTXW-1:0]   ch_ctx_d [N_ENG];
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [63:0]       host_src_q, host_src_d;
    logic [CTXW-1:0]   host_ctx_q, host_ctx_d;
    logic [N_ENG-1:0]  eng_ack_q, eng_ack_d;
    logic [N_ENG-1:0]  ovf_q, ovf_d;
    logic [N_ENG-1:0]  tmo_q, tmo_d;

    logic [63:0]       eng_src_s [N_ENG];
    logic [CTXW-1:0]   eng_ctx_s [N_ENG];
    logic [N_ENG-1:0]  grant_oh;
    logic [N_ENG-1:0]  clr_oh;
    logic [N_ENG-1:0]  capture;
    logic [N_ENG-1:0]  drop;
    logic [N_ENG-1:0]  tmo_set;
    logic              ack_fire;
    logic              tmo_fire;
    logic              issue;
    logic              rr_found;
    logic [GW-1:0]     rr_idx;
    int                rr_pos;

    // A request is taken when the slot is free or is being freed by the
    // acknowledge in this very cycle; otherwise it is an overflow.
    generate
        for (genvar gi = 0; gi < N_ENG; gi++) begin : g_chan
            assign eng_src_s[gi] = eng_src[64*gi +: 64];
            assign eng_ctx_s[gi] = eng_ctx[CTXW*gi +: CTXW];
            assign capture[gi]   = eng_req[gi] & (~pending_q[gi] | clr_oh[gi]);
            assign drop[gi]      = eng_req[gi] & pending_q[gi] & ~clr_oh[gi];
        end
    endgenerate

    // Acknowledge and timeout decode; last_grant doubles as the current grant in WAIT.
    always_comb begin
        grant_oh               = '0;
        grant_oh[last_grant_q] = 1'b1;
        ack_fire = (state_q == S_WAIT) && host_ack;
        tmo_fire = (state_q == S_WAIT) && !host_ack && (wait_cnt_q == CW'(TIMEOUT - 1));
        clr_oh   = ack_fire ? grant_oh : '0;
        issue    = (state_q == S_IDLE) && (|pending_q);
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_pos   = 0;
        for (int k = 1; k <= N_ENG; k++) begin
            rr_pos = int'(last_grant_q) + k;
            if (rr_pos >= N_ENG) begin
                rr_pos = rr_pos - N_ENG;
            end
            if (!rr_found && pending_q[rr_pos[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_pos[GW-1:0];
            end
        end
    end

    // Channel slots and sticky status; a new sticky event beats a clear.
    always_comb begin
        pending_d = (pending_q & ~clr_oh) | capture;
        for (int i = 0; i < N_ENG; i++) begin
            ch_src_d[i] = capture[i] ? eng_src_s[i] : ch_src_q[i];
            ch_ctx_d[i] = capture[i] ? eng_ctx_s[i] : ch_ctx_q[i];
        end
        ovf_d = (ovf_q & {N_ENG{~sticky_clr}}) | drop;
        tmo_d = (tmo_q & {N_ENG{~sticky_clr}}) | tmo_set;
    end

    // Issue bookkeeping: latch the granted channel's data, run the wait counter.
    always_comb begin
        last_grant_d = last_grant_q;
        host_src_d   = host_src_q;
        host_ctx_d   = host_ctx_q;
        wait_cnt_d   = wait_cnt_q;
        eng_ack_d    = '0;
        tmo_set      = '0;
        if (issue) begin
            last_grant_d = rr_idx;
            host_src_d   = ch_src_q[rr_idx];
            host_ctx_d   = ch_ctx_q[rr_idx];
            wait_cnt_d   = '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (ack_fire) begin
                eng_ack_d = grant_oh;
            end else if (tmo_fire) begin
                tmo_set = grant_oh;
            end
        end
    end

    // FSM next state: every exit from WAIT lands in IDLE for at least one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_WAIT;
            S_WAIT:  if (ack_fire || tmo_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output: the host request level is exactly the WAIT state.
    always_comb begin
        host_req = (state_q == S_WAIT);
    end

    // All state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            last_grant_q <= GW'(N_ENG - 1);
            wait_cnt_q   <= '0;
            host_src_q   <= '0;
            host_ctx_q   <= '0;
            eng_ack_q    <= '0;
            ovf_q        <= '0;
            tmo_q        <= '0;
            for (int i = 0; i < N_ENG; i++) begin
                ch_src_q[i] <= '0;
                ch_ctx_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            host_src_q   <= host_src_d;
            host_ctx_q   <= host_ctx_d;
            eng_ack_q    <= eng_ack_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            for (int i = 0; i < N_ENG; i++) begin
                ch_src_q[i] <= ch_src_d[i];
                ch_ctx_q[i] <= ch_ctx_d[i];
            end
        end
    end

    assign host_src   = host_src_q;
    assign host_ctx   = host_ctx_q;
    assign eng_ack    = eng_ack_q;
    assign ovf_sticky = ovf_q;
    assign tmo_sticky = tmo_q;

endmodule
